// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative shift-add multiply / restoring divide holding the HI/LO pair.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic [4:0]       iControlSignal,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic [WIDTH-1:0] oHI,
  output logic [WIDTH-1:0] oLO,
  output logic             oBusy,
  output logic             oDone
);
  localparam logic [4:0] OPMULT  = 5'd10;
  localparam logic [4:0] OPMULTU = 5'd11;
  localparam logic [4:0] OPDIV   = 5'd12;
  localparam logic [4:0] OPDIVU  = 5'd13;
  localparam logic [4:0] OPMTHI  = 5'd14;
  localparam logic [4:0] OPMTLO  = 5'd15;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [WIDTH-1:0] b_q, b_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] abs_a, abs_b, quo, rem;
  logic div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;
  logic [WIDTH:0] msum, dsh, ddif;
  logic is_md, is_dv, sgn, ge;
  always_comb begin
    is_md = iControlSignal inside {OPMULT, OPMULTU, OPDIV, OPDIVU};
    is_dv = iControlSignal inside {OPDIV, OPDIVU};
    sgn = iControlSignal inside {OPMULT, OPDIV};
    abs_a = (sgn && iA[WIDTH-1]) ? -iA : iA;
    abs_b = (sgn && iB[WIDTH-1]) ? -iB : iB;
    msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? b_q : {WIDTH{1'b0}}};
    // acc holds {remainder, dividend/quotient}; remainder < divisor keeps dsh within WIDTH+1 bits
    dsh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ge = dsh >= {1'b0, b_q};
    ddif = dsh - {1'b0, b_q};
    prod = neg_q ? -acc_q : acc_q;
    quo = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    b_d = b_q;
    a_d = a_q;
    hi_d = hi_q;
    lo_d = lo_q;
    div_d = div_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    dz_d = dz_q;
    done_d = 1'b0;
    if (state_q == IDLE && iStart && is_md) begin
      state_d = RUN;
      cnt_d = '0;
      acc_d = {{WIDTH{1'b0}}, is_dv ? abs_a : abs_b};
      b_d = is_dv ? abs_b : abs_a;
      a_d = iA;
      div_d = is_dv;
      neg_d = sgn && (iA[WIDTH-1] ^ iB[WIDTH-1]);
      rneg_d = sgn && iA[WIDTH-1];
      dz_d = is_dv && iB == '0;
    end else if (state_q == IDLE && iStart) begin
      hi_d = iControlSignal == OPMTHI ? iA : hi_q;
      lo_d = iControlSignal == OPMTLO ? iA : lo_q;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + 1'b1;
      acc_d = div_q ? {ge ? ddif[WIDTH-1:0] : dsh[WIDTH-1:0], acc_q[WIDTH-2:0], ge}
                    : {msum, acc_q[WIDTH-1:1]};
      state_d = cnt_q == CW'(WIDTH - 1) ? FIX : RUN;
    end else if (state_q == FIX) begin
      state_d = IDLE;
      done_d = 1'b1;
      hi_d = dz_q ? a_q : div_q ? rem : prod[2*WIDTH-1:WIDTH];
      lo_d = dz_q ? {WIDTH{1'b1}} : div_q ? quo : prod[WIDTH-1:0];
    end
  end
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      b_q <= '0;
      a_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      b_q <= b_d;
      a_q <= a_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      div_q <= div_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      dz_q <= dz_d;
      done_q <= done_d;
    end
  end
  assign oHI = hi_q;
  assign oLO = lo_q;
  assign oBusy = state_q != IDLE;
  assign oDone = done_q;
endmodule
